// File: rtl/sm_step_ctrl.sv
// Execution controller for the schoolMIPS core: turns run switch, step button and
// rate setting into a single-instruction core enable, with PC breakpoint support.
module sm_step_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [3:0]  clkDevide,
    input  logic [31:0] pc,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        cpu_en,
    output logic        halted,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Bit 0 carries run, bit 1 carries step through identical two-flop synchronizers.
    logic [1:0] async_in;
    logic [1:0] sync_meta_q;
    logic [1:0] sync_q;

    assign async_in = {step, run};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_meta_q[gi] <= 1'b0;
                    sync_q[gi]      <= 1'b0;
                end else begin
                    sync_meta_q[gi] <= async_in[gi];
                    sync_q[gi]      <= sync_meta_q[gi];
                end
            end
        end
    endgenerate

    logic run_s;
    logic step_s;

    assign run_s  = sync_q[0];
    assign step_s = sync_q[1];

    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_db_q, step_db_d;
    logic             step_db_dly_q;
    logic             step_req_q;

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        step_db_d = step_db_q;
        if (step_s == step_db_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            step_db_d = step_s;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] div_limit;
    logic        tick;
    logic        bp_hit;
    state_t      state_q, state_d;

    assign div_limit = 16'((17'd1 << clkDevide) - 17'd1);
    assign tick      = (div_cnt_q == div_limit);
    assign bp_hit    = bp_en & (pc == bp_addr);

    always_comb begin
        if (state_q != ST_RUN || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    // A tick that lands on the breakpoint is withheld so the core stops before bp_addr.
    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                cpu_en = step_req_q;
                if (run_s) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!run_s) begin
                    state_d = ST_PAUSE;
                end else if (tick && bp_hit) begin
                    state_d = ST_BREAK;
                end else begin
                    cpu_en = tick;
                end
            end
            ST_BREAK: begin
                cpu_en = step_req_q;
                if (step_req_q || !run_s) state_d = ST_PAUSE;
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
    end

    logic        halted_q;
    logic [15:0] step_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_PAUSE;
            halted_q      <= 1'b1;
            step_cnt_q    <= '0;
            div_cnt_q     <= '0;
            deb_cnt_q     <= '0;
            step_db_q     <= 1'b0;
            step_db_dly_q <= 1'b0;
            step_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            halted_q      <= (state_d != ST_RUN);
            step_cnt_q    <= step_cnt_q + 16'(cpu_en);
            div_cnt_q     <= div_cnt_d;
            deb_cnt_q     <= deb_cnt_d;
            step_db_q     <= step_db_d;
            step_db_dly_q <= step_db_q;
            step_req_q    <= step_db_q & ~step_db_dly_q;
        end
    end

    assign halted   = halted_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Scoreboard bench for sm_step_ctrl: expected enable cycles are derived from the
// timing rules (sync, debounce, divider, breakpoint) and matched as enables appear.
module tb_sm_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic [3:0]  clkDevide;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_en;
    logic        halted;
    logic [15:0] step_cnt;

    sm_step_ctrl #(
        .DEB_CYCLES(4),
        .DEB_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .clkDevide(clkDevide),
        .pc       (pc),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .cpu_en   (cpu_en),
        .halted   (halted),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The core advances pc by one word in the cycle after each enable.
    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic push_en(input int c);
        exp_t e;
        e.cyc = c;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_en cyc=%0d step_cnt=%0d required no enable", cyc, step_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.cnt !== step_cnt) begin
                    n_fail++;
                    $display("FAIL en_timing got cyc=%0d cnt=%0d required cyc=%0d cnt=%0d",
                             cyc, step_cnt, mon_e.cyc, mon_e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h at cyc=%0d", name, got, want, cyc);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        adv(12);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        adv(3);
        rst     = 1'b0;
        exp_cnt = 16'd0;
        adv(1);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_step_cnt", 32'(step_cnt), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
    endtask

    // Free-run window: RUN is entered 3 edges after run rises, the last enable
    // can fall one cycle after run drops (two sync stages).
    task automatic run_phase(input int dur, input bit poke);
        int r;
        int per;
        r   = cyc;
        per = 1 << clkDevide;
        run = 1'b1;
        for (int c = r + 3; c <= r + dur + 1; c++) begin
            if (((c - (r + 3) + 1) % per) == 0) push_en(c);
        end
        if (poke) begin
            adv(5);
            step = 1'b1;
            adv(6);
            step = 1'b0;
            adv(dur - 11);
        end else begin
            adv(dur);
        end
        check("halted_in_run", 32'(halted), 32'd0);
        run = 1'b0;
        adv(4);
        check("halted_after_run", 32'(halted), 32'd1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int r;
        int len;
        int k;
        int per;
        int tb;
        int f;
        rst       = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        clkDevide = 4'd0;
        bp_en     = 1'b0;
        bp_addr   = 32'd0;
        exp_cnt   = 16'd0;
        do_reset();

        // Single clean press
        p    = cyc;
        step = 1'b1;
        push_en(p + 7);
        adv(20);
        step = 1'b0;
        adv(15);
        check("single_step_cnt", 32'(step_cnt), 32'd1);
        check("single_step_halted", 32'(halted), 32'd1);
        drain("single_step_drain");

        // Bounce
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step = 1'b1;
            adv(2);
            step = 1'b0;
            adv(2);
        end
        adv(10);
        check("bounce_cnt", 32'(step_cnt), 32'd0);
        drain("bounce_drain");

        // Random presses and glitches in PAUSE
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) len = $urandom_range(4, 15);
            else len = $urandom_range(1, 3);
            p    = cyc;
            step = 1'b1;
            if (len >= 4) push_en(p + 7);
            adv(len);
            step = 1'b0;
            adv($urandom_range(14, 20));
        end
        check("rand_step_cnt", 32'(step_cnt), 32'(exp_cnt));
        drain("rand_step_drain");

        // Run rate at clkDevide = 3 over an 80-cycle window
        do_reset();
        clkDevide = 4'd3;
        adv(2);
        run_phase(81, 1'b0);
        check("rate3_pulses", 32'(step_cnt), 32'd10);
        clkDevide = 4'd0;
        adv(2);
        run_phase(20, 1'b0);
        check("rate0_pulses", 32'(step_cnt), 32'd29);
        drain("rate_drain");

        // Random rates, some with a step press during RUN (must be ignored)
        for (int i = 0; i < 6; i++) begin
            clkDevide = 4'($urandom_range(0, 4));
            adv(2);
            run_phase($urandom_range(20, 80), 1'($urandom_range(0, 1)));
            adv(6);
        end
        check("rand_run_cnt", 32'(step_cnt), 32'(exp_cnt));
        drain("rand_run_drain");

        // Breakpoint, single step out of BREAK, resume
        do_reset();
        clkDevide = 4'($urandom_range(0, 2));
        k         = $urandom_range(2, 5);
        per       = 1 << clkDevide;
        bp_en     = 1'b1;
        bp_addr   = 32'(4 * k);
        adv(2);
        r   = cyc;
        run = 1'b1;
        for (int n = 1; n <= k; n++) push_en(r + 2 + n * per);
        tb = r + 2 + (k + 1) * per;
        adv(tb + 3 - r);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_cnt", 32'(step_cnt), 32'(k));
        adv(10);
        check("bp_hold_halted", 32'(halted), 32'd1);
        p    = cyc;
        step = 1'b1;
        push_en(p + 7);
        f = p + 9 + 6 * per + 2;
        for (int c = p + 9; c <= f + 1; c++) begin
            if (((c - (p + 9) + 1) % per) == 0) push_en(c);
        end
        adv(5);
        step = 1'b0;
        adv(p + 10 - cyc);
        check("bp_resume_halted", 32'(halted), 32'd0);
        adv(f - cyc);
        run = 1'b0;
        adv(4);
        check("bp_end_halted", 32'(halted), 32'd1);
        check("bp_end_cnt", 32'(step_cnt), 32'(exp_cnt));
        drain("bp_drain");
        bp_en = 1'b0;

        // run falling together with tick and breakpoint hit
        do_reset();
        clkDevide = 4'd0;
        k         = $urandom_range(2, 5);
        bp_en     = 1'b1;
        bp_addr   = 32'(4 * k);
        adv(2);
        r   = cyc;
        run = 1'b1;
        for (int n = 0; n < k; n++) push_en(r + 3 + n);
        adv(k + 1);
        run = 1'b0;
        adv(4);
        check("prio_halted", 32'(halted), 32'd1);
        check("prio_cnt", 32'(step_cnt), 32'(k));
        drain("prio_drain");
        bp_en = 1'b0;

        // Reset in the middle of a debounce count
        do_reset();
        step = 1'b1;
        adv(5);
        rst  = 1'b1;
        step = 1'b0;
        adv(1);
        check("middeb_rst_cnt", 32'(step_cnt), 32'd0);
        check("middeb_rst_halted", 32'(halted), 32'd1);
        rst     = 1'b0;
        exp_cnt = 16'd0;
        adv(15);
        check("middeb_after_cnt", 32'(step_cnt), 32'd0);
        drain("middeb_drain");

        // 65536 enables wrap the counter back to zero
        do_reset();
        clkDevide = 4'd0;
        adv(2);
        run_phase(65537, 1'b0);
        check("wrap_cnt", 32'(step_cnt), 32'd0);
        drain("wrap_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_step_ctrl.md
# sm_step_ctrl

Execution controller for the schoolMIPS core on the DE0 board. It turns the run switch, the step pushbutton and the 4-bit clock-divide setting into a single core clock-enable, `cpu_en`. It supports free-running at a programmable rate, single-stepping and a PC breakpoint. It sits between the board I/O and `sm_top`, and drives the core's register-enable path and the status LEDs.

## Interface
- `DEB_CYCLES`, default 50000: consecutive stable cycles required to accept a step-button change (1 ms at 50 MHz).
- `DEB_W`, default 16: debounce counter width. Must satisfy 2^DEB_W > DEB_CYCLES.

- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset. Reset is synchronous and active-high.
- `run` in 1: asynchronous level from a switch; 1 = free-run requested.
- `step` in 1: asynchronous raw step button, active-high (already inverted at board level).
- `clkDevide` in 4: run rate; one enable every 2^clkDevide cycles.
- `pc` in 32: current core PC, stable between enables.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint address.
- `cpu_en` out 1: core enable. Combinational from state and registered signals. Exactly one core instruction per asserted cycle.
- `halted` out 1: registered; 1 whenever state is not RUN.
- `step_cnt` out 16: registered count of `cpu_en` cycles.

## Operation
- **Synchronizers:** `run` and `step` each pass through two flops, producing `run_s` and `step_s`.
- **Debounce:**
  - `step_db` takes `step_s` only after `step_s != step_db` has held for DEB_CYCLES consecutive cycles.
  - Any cycle with `step_s == step_db` clears the counter.
  - `step_req` is a one-cycle pulse on each 0→1 transition of `step_db`.
- **Divider:**
  - `div_cnt` is DEB_W... no: `div_cnt` is 16 bits.
  - `tick = (div_cnt == 2^clkDevide − 1)`.
  - `div_cnt` returns to 0 on `tick`, otherwise increments.
  - `div_cnt` is forced to 0 in any cycle where the state is not RUN.
  - `clkDevide = 0` gives `tick` every cycle.
  - A change of `clkDevide` while `div_cnt` is already above the new limit causes `div_cnt` to wrap naturally through 0xFFFF; this is acceptable.
- **Breakpoint:** `bp_hit = bp_en & (pc == bp_addr)`.
- **FSM** (states PAUSE, RUN, BREAK; reset state is PAUSE). Evaluated each cycle in the priority order listed:
  - PAUSE:
    - `cpu_en = step_req`. Breakpoints are ignored, so a step always executes.
    - `run_s = 1` → RUN.
  - RUN:
    - `run_s = 0` → PAUSE; `cpu_en = 0` this cycle.
    - Else if `tick & bp_hit` → BREAK; `cpu_en = 0`, so the instruction at `bp_addr` is not executed.
    - Else `cpu_en = tick`.
  - BREAK:
    - `cpu_en = step_req`.
    - `step_req` → PAUSE. The stepped instruction at `bp_addr` executes.
    - `run_s = 0` → PAUSE with no enable.
    - `run_s = 1` alone does not resume.
- **Counter:** `step_cnt` increments on every `cpu_en` cycle and wraps from 0xFFFF to 0x0000.

## Timing
- **Reset:** `rst = 1` at a clock edge sets:
  - state to PAUSE;
  - all synchronizer flops, `step_db`, the debounce counter, `div_cnt` and `step_cnt` to 0;
  - `halted` to 1;
  - `cpu_en` to 0 during and after reset, because `step_req` is 0.
- **Reset mid-operation:** aborts any pending debounce or divider count. No `cpu_en` pulse may occur in the cycle following reset release.
- **Step latency:** a clean press reaches `cpu_en` after 2 sync cycles + DEB_CYCLES + 1 edge-detect cycle. The pulse lasts exactly 1 cycle, regardless of press length.
- **Bounce:** pulses shorter than DEB_CYCLES produce no `step_req`. Release does not produce a pulse.
- **Run entry:** first `tick` occurs 2^clkDevide cycles after the state becomes RUN; at `clkDevide = 0`, the cycle after entry.
- **`halted` update:** `halted` updates on the same edge as the state register.
- **`pc`:** assumed constant except in the cycle following `cpu_en`. The breakpoint compare is combinational and is evaluated on the `tick` cycle.
- **Simultaneous events:**
  - In RUN, `run_s` falling together with `tick & bp_hit` goes to PAUSE, not BREAK.
  - In BREAK, `step_req` together with `run_s = 0` gives one enable, then PAUSE.
  - `step_req` while in RUN is ignored.

## Test plan
- **Single step in PAUSE** (DEB_CYCLES = 4, reset then clean press held 20 cycles): exactly one `cpu_en` pulse, 7 cycles after the press; `step_cnt = 1`; `halted = 1` throughout.
- **Bounce rejection:** step toggling every 2 cycles for 40 cycles, then low → no `cpu_en`; `step_cnt = 0`.
- **Run rate:** `run = 1`, `clkDevide = 3`, for 80 cycles after entering RUN → `cpu_en` every 8th cycle, 10 pulses; `halted = 0`. `clkDevide = 0` → `cpu_en` every cycle.
- **Breakpoint:** `bp_en = 1`, `bp_addr = 0x0000000C`, `pc` advancing by 4 per enable from 0 (`clkDevide = 0`):
  - 3 enables, then BREAK with `pc = 0x0C` and `halted = 1`;
  - one step → 1 enable, PAUSE;
  - `run` held at 1 → RUN resumes next cycle.
- **Priority and reset:**
  - In RUN with `tick`, `bp_hit` and `run` falling together → PAUSE, no enable.
  - `rst` asserted mid-debounce (count 3 of 4) → counters 0, no pulse after release.
- **Wrap:** force 65536 enables at `clkDevide = 0` → `step_cnt` returns to 0x0000.
